// File: rtl/uart_cmd_bridge_pkg.sv
// Shared command codes, parser state encodings and the status byte layout
// for the UART command bridge.
package uart_cmd_bridge_pkg;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_PING   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ARG   = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_RESP0 = 3'd4;
  localparam logic [2:0] ST_RESP1 = 3'd5;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       tx_full;
    logic       rx_full;
    logic       frame_err;
    logic       rx_overflow;
  } status_t;

  function automatic logic [7:0] pack_status(input logic tx_full, input logic rx_full,
                                             input logic frame_err, input logic rx_overflow);
    status_t s;
    s.rsvd        = 4'b0;
    s.tx_full     = tx_full;
    s.rx_full     = rx_full;
    s.frame_err   = frame_err;
    s.rx_overflow = rx_overflow;
    return s;
  endfunction

endpackage

// File: rtl/uart_cmd_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible on pop_data
// whenever the FIFO is not empty. DEPTH must be a power of 2.
module uart_cmd_bridge_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count_q == LW'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_en    = push && !full;
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en) begin
      count_d = count_q + LW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only occupied entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// Buffers rxuart bytes, parses SYNC/CMD/ARG frames, drives the frame-write
// pulse and queues 2-byte responses that drain into txuart under tx_busy.
module uart_cmd_bridge
  import uart_cmd_bridge_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned RX_DEPTH       = 16,
  parameter int unsigned TX_DEPTH       = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_valid,
  input  logic [DATA_W-1:0]           rx_data,
  input  logic                        tx_busy,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        start_write_frame,
  output logic [7:0]                  frame_arg,
  input  logic                        status_clear,
  output logic                        rx_overflow,
  output logic                        frame_err,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(TX_DEPTH):0]   tx_level
);

  localparam int unsigned TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned PC_W  = $clog2(PULSE_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic [DATA_W-1:0] arg_q, arg_d;
  logic [DATA_W-1:0] resp0_q, resp0_d;
  logic [DATA_W-1:0] resp1_q, resp1_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [PC_W-1:0]   pulse_q, pulse_d;
  logic [7:0]        frame_arg_q, frame_arg_d;
  logic              swf_q, swf_d;
  logic              rx_overflow_q, rx_overflow_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              holdoff_q, holdoff_d;

  logic              rx_full, rx_empty, rx_push_c, rx_pop_c;
  logic [DATA_W-1:0] rx_head;
  logic              tx_full, tx_empty, tx_push_c, tx_pop_c;
  logic [DATA_W-1:0] tx_push_data_c, tx_head;
  logic              frame_err_set_c;

  assign rx_push_c = rx_valid && !rx_full;

  uart_cmd_bridge_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_c),
    .push_data (rx_data),
    .pop       (rx_pop_c),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  uart_cmd_bridge_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push_c),
    .push_data (tx_push_data_c),
    .pop       (tx_pop_c),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  // Frame parser, command decode and response generation.
  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    arg_d           = arg_q;
    resp0_d         = resp0_q;
    resp1_d         = resp1_q;
    to_cnt_d        = '0;
    pulse_d         = (pulse_q != '0) ? pulse_q - PC_W'(1) : pulse_q;
    frame_arg_d     = frame_arg_q;
    frame_err_set_c = 1'b0;
    rx_pop_c        = 1'b0;
    tx_push_c       = 1'b0;
    tx_push_data_c  = resp0_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_empty) begin
          rx_pop_c = 1'b1;
          if (rx_head == DATA_W'(SYNC_BYTE)) state_d = ST_CMD;
        end
      end
      ST_CMD, ST_ARG: begin
        if (!rx_empty) begin
          rx_pop_c = 1'b1;
          if (state_q == ST_CMD) begin
            cmd_d   = rx_head;
            state_d = ST_ARG;
          end else begin
            arg_d   = rx_head;
            state_d = ST_EXEC;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d         = ST_IDLE;
          frame_err_set_c = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_EXEC: begin
        // Both response bytes must fit before committing to the command.
        if (tx_level <= TX_LW'(TX_DEPTH - 2)) begin
          state_d = ST_RESP0;
          resp0_d = DATA_W'(ACK);
          case (cmd_q)
            DATA_W'(CMD_START): begin
              frame_arg_d = 8'(arg_q);
              pulse_d     = PC_W'(PULSE_CYCLES);
              resp1_d     = DATA_W'(CMD_START);
            end
            DATA_W'(CMD_PING): resp1_d = arg_q;
            DATA_W'(CMD_STATUS):
              resp1_d = DATA_W'(pack_status(tx_full, rx_full, frame_err_q, rx_overflow_q));
            default: begin
              frame_err_set_c = 1'b1;
              resp0_d         = DATA_W'(NAK);
              resp1_d         = cmd_q;
            end
          endcase
        end
      end
      ST_RESP0: begin
        tx_push_c      = 1'b1;
        tx_push_data_c = resp0_q;
        state_d        = ST_RESP1;
      end
      ST_RESP1: begin
        tx_push_c      = 1'b1;
        tx_push_data_c = resp1_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags (set beats clear), pulse output and txuart drain handshake.
  always_comb begin
    rx_overflow_d = rx_overflow_q;
    frame_err_d   = frame_err_q;
    if (status_clear) begin
      rx_overflow_d = 1'b0;
      frame_err_d   = 1'b0;
    end
    if (rx_valid && rx_full) rx_overflow_d = 1'b1;
    if (frame_err_set_c)     frame_err_d   = 1'b1;
    swf_d      = (pulse_d != '0);
    tx_pop_c   = !tx_empty && !tx_busy && !tx_valid_q && !holdoff_q;
    tx_valid_d = tx_pop_c;
    tx_data_d  = tx_pop_c ? tx_head : tx_data_q;
    holdoff_d  = tx_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      arg_q         <= '0;
      resp0_q       <= '0;
      resp1_q       <= '0;
      to_cnt_q      <= '0;
      pulse_q       <= '0;
      frame_arg_q   <= '0;
      swf_q         <= 1'b0;
      rx_overflow_q <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      holdoff_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      arg_q         <= arg_d;
      resp0_q       <= resp0_d;
      resp1_q       <= resp1_d;
      to_cnt_q      <= to_cnt_d;
      pulse_q       <= pulse_d;
      frame_arg_q   <= frame_arg_d;
      swf_q         <= swf_d;
      rx_overflow_q <= rx_overflow_d;
      frame_err_q   <= frame_err_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      holdoff_q     <= holdoff_d;
    end
  end

  assign tx_valid          = tx_valid_q;
  assign tx_data           = tx_data_q;
  assign start_write_frame = swf_q;
  assign frame_arg         = frame_arg_q;
  assign rx_overflow       = rx_overflow_q;
  assign frame_err         = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: directed frames plus a randomized
// frame stream compared against a byte-stream reference model.
module tb_uart_cmd_bridge;

  localparam int unsigned RXD      = 16;
  localparam int unsigned TXD      = 4;
  localparam int unsigned PC       = 4;
  localparam int unsigned TO       = 50;
  localparam int          BUSY_LEN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       start_write_frame;
  logic [7:0] frame_arg;
  logic       status_clear;
  logic       rx_overflow;
  logic       frame_err;
  logic [4:0] rx_level;
  logic [2:0] tx_level;

  uart_cmd_bridge #(
    .DATA_W(8), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .SYNC_BYTE(8'hA5),
    .PULSE_CYCLES(PC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_valid(tx_valid), .tx_data(tx_data),
    .start_write_frame(start_write_frame), .frame_arg(frame_arg),
    .status_clear(status_clear), .rx_overflow(rx_overflow), .frame_err(frame_err),
    .rx_level(rx_level), .tx_level(tx_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Monitor state: received txuart bytes, txuart busy model, pulse statistics.
  logic [7:0] rcv_q[$];
  int   busy_cnt = 0;
  int   viol = 0;
  int   tx_count = 0;
  int   sw_rises = 0;
  int   sw_width = 0;
  int   sw_last_width = 0;
  logic hold_busy = 1'b0;
  logic [7:0] model_arg = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      sw_width = 0;
    end else begin
      if (tx_valid) begin
        if (busy_cnt != 0 || hold_busy) viol++;
        rcv_q.push_back(tx_data);
        tx_count++;
        busy_cnt = BUSY_LEN;
      end else if (busy_cnt != 0) begin
        busy_cnt--;
      end
      if (start_write_frame) begin
        if (sw_width == 0) sw_rises++;
        sw_width++;
      end else if (sw_width != 0) begin
        sw_last_width = sw_width;
        sw_width = 0;
      end
    end
    tx_busy = hold_busy || (busy_cnt != 0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (rcv_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    status_clear = 1'b1;
    @(negedge clk);
    status_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (start_write_frame !== 1'b0) begin errors++; $display("FAIL reset_swf: got %b want 0", start_write_frame); end
    checks++; if (frame_arg !== 8'h00) begin errors++; $display("FAIL reset_frame_arg: got %h want 00", frame_arg); end
    checks++; if ({rx_overflow, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {rx_overflow, frame_err}); end
    checks++; if ({rx_level, tx_level} !== 8'h00) begin errors++; $display("FAIL reset_levels: got rx=%0d tx=%0d want 0", rx_level, tx_level); end
  endtask

  task automatic test_start();
    int base = rcv_q.size();
    int r0 = sw_rises;
    send_byte(8'hA5, 2); send_byte(8'h01, 2); send_byte(8'h3C, 2);
    wait_bytes(base + 2, 300);
    wait_cycles(15);
    model_arg = 8'h3C;
    checks++; if (rcv_q.size() != base + 2) begin errors++; $display("FAIL start_count: got %0d bytes want 2", rcv_q.size() - base); end
    else begin
      checks++; if (rcv_q[base] !== 8'h06) begin errors++; $display("FAIL start_b0: got %h want 06", rcv_q[base]); end
      checks++; if (rcv_q[base+1] !== 8'h01) begin errors++; $display("FAIL start_b1: got %h want 01", rcv_q[base+1]); end
    end
    checks++; if (sw_rises - r0 != 1) begin errors++; $display("FAIL start_edges: got %0d want 1", sw_rises - r0); end
    checks++; if (sw_last_width != PC) begin errors++; $display("FAIL start_width: got %0d want %0d", sw_last_width, PC); end
    checks++; if (frame_arg !== 8'h3C) begin errors++; $display("FAIL start_arg: got %h want 3c", frame_arg); end
  endtask

  task automatic test_discard();
    int base = rcv_q.size();
    int r0 = sw_rises;
    send_byte(8'h11, 1); send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h7E, 1);
    wait_bytes(base + 2, 300);
    wait_cycles(15);
    checks++; if (rcv_q.size() != base + 2) begin errors++; $display("FAIL ping_count: got %0d bytes want 2", rcv_q.size() - base); end
    else begin
      checks++; if ({rcv_q[base], rcv_q[base+1]} !== 16'h067E) begin errors++; $display("FAIL ping_resp: got %h%h want 067e", rcv_q[base], rcv_q[base+1]); end
    end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ping_frame_err: got %b want 0", frame_err); end
    checks++; if (sw_rises != r0) begin errors++; $display("FAIL ping_no_pulse: got %0d edges want 0", sw_rises - r0); end
  endtask

  task automatic test_bad_cmd();
    int base = rcv_q.size();
    send_byte(8'hA5, 1); send_byte(8'h09, 1); send_byte(8'h00, 1);
    wait_bytes(base + 2, 300);
    wait_cycles(15);
    checks++; if (rcv_q.size() != base + 2) begin errors++; $display("FAIL nak_count: got %0d bytes want 2", rcv_q.size() - base); end
    else begin
      checks++; if ({rcv_q[base], rcv_q[base+1]} !== 16'h1509) begin errors++; $display("FAIL nak_resp: got %h%h want 1509", rcv_q[base], rcv_q[base+1]); end
    end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL nak_frame_err: got %b want 1", frame_err); end
    checks++; if (frame_arg !== model_arg) begin errors++; $display("FAIL nak_arg_kept: got %h want %h", frame_arg, model_arg); end
    pulse_clear();
    wait_cycles(1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL clear_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_timeout();
    int base = rcv_q.size();
    send_byte(8'hA5, 0);
    wait_cycles(40);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", frame_err); end
    wait_cycles(25);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", frame_err); end
    checks++; if (rcv_q.size() != base) begin errors++; $display("FAIL timeout_no_tx: got %0d bytes want 0", rcv_q.size() - base); end
    pulse_clear();
    base = rcv_q.size();
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h55, 1);
    wait_bytes(base + 2, 300);
    wait_cycles(15);
    checks++; if (rcv_q.size() != base + 2) begin errors++; $display("FAIL recover_count: got %0d bytes want 2", rcv_q.size() - base); end
    else begin
      checks++; if ({rcv_q[base], rcv_q[base+1]} !== 16'h0655) begin errors++; $display("FAIL recover_resp: got %h%h want 0655", rcv_q[base], rcv_q[base+1]); end
    end
  endtask

  task automatic test_back_pressure();
    int base;
    int tc0;
    @(negedge clk);
    hold_busy = 1'b1;
    wait_cycles(3);
    base = rcv_q.size();
    tc0 = tx_count;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'hB0 + 8'(i), 0);
    end
    wait_cycles(20);
    checks++; if (tx_level !== 3'(TXD)) begin errors++; $display("FAIL bp_tx_level: got %0d want %0d", tx_level, TXD); end
    checks++; if (rx_level !== 5'd6) begin errors++; $display("FAIL bp_rx_level: got %0d want 6", rx_level); end
    checks++; if (tx_count != tc0) begin errors++; $display("FAIL bp_held: got %0d writes want 0", tx_count - tc0); end
    for (int i = 0; i < 17; i++) send_byte(8'h00, 0);
    wait_cycles(3);
    checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b want 1", rx_overflow); end
    checks++; if (rx_level !== 5'(RXD)) begin errors++; $display("FAIL bp_rx_full: got %0d want %0d", rx_level, RXD); end
    @(negedge clk);
    hold_busy = 1'b0;
    wait_bytes(base + 10, 1000);
    wait_cycles(40);
    checks++; if (rcv_q.size() != base + 10) begin errors++; $display("FAIL bp_count: got %0d bytes want 10", rcv_q.size() - base); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if ({rcv_q[base+2*i], rcv_q[base+2*i+1]} !== {8'h06, 8'hB0 + 8'(i)})
          begin errors++; $display("FAIL bp_resp%0d: got %h%h want 06%h", i, rcv_q[base+2*i], rcv_q[base+2*i+1], 8'hB0 + 8'(i)); end
      end
    end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bp_frame_err: got %b want 0", frame_err); end
    base = rcv_q.size();
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h00, 1);
    wait_bytes(base + 2, 300);
    wait_cycles(15);
    checks++; if (rcv_q.size() != base + 2) begin errors++; $display("FAIL status_count: got %0d bytes want 2", rcv_q.size() - base); end
    else begin
      checks++; if ({rcv_q[base], rcv_q[base+1]} !== 16'h0601) begin errors++; $display("FAIL status_resp: got %h%h want 0601", rcv_q[base], rcv_q[base+1]); end
    end
    pulse_clear();
    wait_cycles(1);
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b want 0", rx_overflow); end
  endtask

  // Reference: scan the sent byte stream for SYNC-led triples and derive responses.
  task automatic test_random();
    logic [7:0] stream[$];
    logic [7:0] exp_q[$];
    logic [7:0] b, c, a;
    logic       exp_err = 1'b0;
    int         n_start = 0;
    int         base = rcv_q.size();
    int         r0 = sw_rises;
    int         i;
    for (int f = 0; f < 16; f++) begin
      int ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        stream.push_back(b);
      end
      case ($urandom_range(0, 3))
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        default: c = 8'($urandom);
      endcase
      stream.push_back(8'hA5);
      stream.push_back(c);
      stream.push_back(8'($urandom));
    end
    foreach (stream[k]) send_byte(stream[k], $urandom_range(2, 6));
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] != 8'hA5) begin
        i++;
      end else if (i + 2 < stream.size()) begin
        c = stream[i+1];
        a = stream[i+2];
        if (c == 8'h01) begin
          exp_q.push_back(8'h06); exp_q.push_back(8'h01);
          model_arg = a; n_start++;
        end else if (c == 8'h02) begin
          exp_q.push_back(8'h06); exp_q.push_back(a);
        end else if (c == 8'h03) begin
          exp_q.push_back(8'h06); exp_q.push_back({6'b0, exp_err, 1'b0});
        end else begin
          exp_q.push_back(8'h15); exp_q.push_back(c);
          exp_err = 1'b1;
        end
        i += 3;
      end else begin
        i = stream.size();
      end
    end
    wait_bytes(base + exp_q.size(), 3000);
    wait_cycles(30);
    checks++; if (rcv_q.size() != base + exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d bytes want %0d", rcv_q.size() - base, exp_q.size()); end
    else begin
      foreach (exp_q[k]) begin
        checks++;
        if (rcv_q[base+k] !== exp_q[k]) begin errors++; $display("FAIL rand_byte%0d: got %h want %h", k, rcv_q[base+k], exp_q[k]); end
      end
    end
    checks++; if (frame_err !== exp_err) begin errors++; $display("FAIL rand_frame_err: got %b want %b", frame_err, exp_err); end
    checks++; if (frame_arg !== model_arg) begin errors++; $display("FAIL rand_frame_arg: got %h want %h", frame_arg, model_arg); end
    checks++; if (sw_rises - r0 != n_start) begin errors++; $display("FAIL rand_edges: got %0d want %0d", sw_rises - r0, n_start); end
    if (n_start > 0) begin
      checks++; if (sw_last_width != PC) begin errors++; $display("FAIL rand_width: got %0d want %0d", sw_last_width, PC); end
    end
    pulse_clear();
  endtask

  task automatic test_reset_pulse();
    int c = 0;
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h77, 1);
    while (start_write_frame !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    checks++; if (start_write_frame !== 1'b1) begin errors++; $display("FAIL rp_pulse_seen: got %b want 1", start_write_frame); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (start_write_frame !== 1'b0) begin errors++; $display("FAIL rp_swf: got %b want 0", start_write_frame); end
    checks++; if (frame_arg !== 8'h00) begin errors++; $display("FAIL rp_arg: got %h want 00", frame_arg); end
    checks++; if ({tx_valid, tx_data, rx_overflow, frame_err} !== 11'h0) begin errors++; $display("FAIL rp_outputs: got %b want 0", {tx_valid, tx_data, rx_overflow, frame_err}); end
    checks++; if ({rx_level, tx_level} !== 8'h00) begin errors++; $display("FAIL rp_levels: got rx=%0d tx=%0d want 0", rx_level, tx_level); end
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(5);
    checks++; if (start_write_frame !== 1'b0) begin errors++; $display("FAIL rp_after: got %b want 0", start_write_frame); end
  endtask

  initial begin
    rst          = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    status_clear = 1'b0;
    test_reset();
    test_start();
    test_discard();
    test_bad_cmd();
    test_timeout();
    test_back_pressure();
    test_random();
    test_reset_pulse();
    checks++; if (viol != 0) begin errors++; $display("FAIL busy_window: got %0d writes during busy want 0", viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
